// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential PCs to a pipelined imem port and buffers the returned words.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_BYPASS_EN.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       stall,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, drop_cnt, count, out_next;
  logic [31:0]   pf_mem [DEPTH];
  logic [AW-1:0] pf_wr, pf_rd;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [AW-1:0] q_wr, q_rd;
  logic [CW:0]   credit_used;
  logic          grant, resp, resp_live, bypass, push, pop;
  logic [31:0]   resp_pc;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Outstanding already includes responses still to be dropped, so the FIFO can never overflow.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign resp_pc     = pf_mem[pf_rd];

  always_comb begin
    imem_req  = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
    imem_addr = fetch_pc;
    grant     = imem_req && imem_gnt;
    resp      = imem_rvalid && (outstanding != '0);
    resp_live = resp && (drop_cnt == '0) && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass    = resp_live && (count == '0) && !reset;
`else
    bypass    = 1'b0;
`endif
    pop       = (count != '0) && !stall && !redirect;
    push      = resp_live && !(bypass && !stall);
    q_count   = count;
    if (count != '0) begin
      inst_valid = 1'b1;
      inst       = q_inst[q_rd];
      inst_pc    = q_pc[q_rd];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = resp_pc;
    end else begin
      inst_valid = 1'b0;
      inst       = NOP_INST;
      inst_pc    = 32'h0;
    end
  end

  // A grant and a response in the same cycle cancel out.
  always_comb begin
    unique case ({grant, resp})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   out_next = outstanding - 1'b1;
      default: out_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grant) pf_mem[pf_wr] <= fetch_pc;
    if (push) begin
      q_inst[q_wr] <= imem_rdata;
      q_pc[q_wr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
    end else begin
      outstanding <= out_next;
      if (grant) begin
        pf_wr    <= pf_wr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp) pf_rd <= pf_rd + 1'b1;
      if (redirect) begin
        // Everything still in flight after this cycle's response is stale.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= out_next;
        count    <= '0;
        q_wr     <= '0;
        q_rd     <= '0;
      end else begin
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) q_wr <= q_wr + 1'b1;
        if (pop)  q_rd <= q_rd + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // A response with nothing outstanding is a memory-side protocol violation.
  always @(posedge clk) begin
    if (!reset && imem_rvalid) assert (outstanding != '0);
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed phases plus random traffic, checked against a
// transaction-level model (queues of in-flight addresses and buffered PCs).
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk, reset;
  logic          imem_req, imem_gnt, imem_rvalid;
  logic [31:0]   imem_addr, imem_rdata;
  logic          redirect, stall;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic [31:0]   inst, inst_pc;
  logic [CW-1:0] q_count;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [31:0] exp_q[$];       // PCs buffered in the queue, head first
  logic [31:0] pend_addr[$];   // granted, not yet answered
  bit          pend_stale[$];
  int          pend_cyc[$];
  logic [31:0] grant_log[$];   // DUT addresses seen at grants
  logic [31:0] exp_addr;
  logic [31:0] last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_addr.delete();
    pend_stale.delete();
    pend_cyc.delete();
    exp_addr = RESET_PC;
    last_pc  = RESET_PC - 32'd4;
  endtask

  task automatic step(input int gnt_pct, input int rv_pct, input int stall_pct,
                      input bit redir, input logic [31:0] tgt);
    bit          ev, er, byp, rv_ok, cons_byp, s;
    logic [31:0] epc, einst, a;
    @(negedge clk);
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    rv_ok       = (pend_addr.size() > 0) && (pend_cyc[0] < cyc);
    imem_rvalid = rv_ok && ($urandom_range(99) < rv_pct);
    imem_rdata  = imem_rvalid ? mem_word(pend_addr[0]) : $urandom;
    stall       = ($urandom_range(99) < stall_pct);
    redirect    = redir;
    redirect_pc = redir ? tgt : $urandom;
    #1;
`ifdef FETCH_BYPASS_EN
    byp = (exp_q.size() == 0) && imem_rvalid && !pend_stale[0] && !redir;
`else
    byp = 1'b0;
`endif
    ev    = (exp_q.size() > 0) || byp;
    epc   = (exp_q.size() > 0) ? exp_q[0] : (byp ? pend_addr[0] : 32'h0);
    einst = ev ? mem_word(epc) : NOP_INST;
    er    = !redir && ((exp_q.size() + pend_addr.size()) < DEPTH);
    chk("imem_req",   32'(imem_req),   32'(er));
    chk("imem_addr",  imem_addr,       exp_addr);
    chk("inst_valid", 32'(inst_valid), 32'(ev));
    chk("inst",       inst,            einst);
    chk("inst_pc",    inst_pc,         epc);
    chk("q_count",    32'(q_count),    32'(exp_q.size()));
    if (er && imem_gnt) grant_log.push_back(imem_addr);
    if (ev && !stall && !redir) begin
      chk("seq_pc", inst_pc, last_pc + 32'd4);
      last_pc = last_pc + 32'd4;
    end
    @(posedge clk);
    if (redir) begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front()); void'(pend_stale.pop_front()); void'(pend_cyc.pop_front());
      end
      exp_q.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      exp_addr = {tgt[31:2], 2'b00};
      last_pc  = exp_addr - 32'd4;
    end else begin
      cons_byp = 1'b0;
      if (ev && !stall) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else cons_byp = 1'b1;
      end
      if (imem_rvalid) begin
        a = pend_addr.pop_front();
        s = pend_stale.pop_front();
        void'(pend_cyc.pop_front());
        if (!s && !cons_byp) exp_q.push_back(a);
      end
      if (er && imem_gnt) begin
        pend_addr.push_back(exp_addr);
        pend_stale.push_back(1'b0);
        pend_cyc.push_back(cyc);
        exp_addr = exp_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'd0);
    chk({tag, "_addr"},  imem_addr,       RESET_PC);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst,            NOP_INST);
    chk({tag, "_pc"},    inst_pc,         32'h0);
    chk({tag, "_cnt"},   32'(q_count),    32'd0);
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    model_clear();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // Always-granting memory answering one cycle after each grant
    repeat (20) step(100, 100, 0, 1'b0, 32'h0);

    // Stalled head while memory keeps granting
    repeat (10) step(100, 100, 100, 1'b0, 32'h0);
    repeat (10) step(100, 100, 0, 1'b0, 32'h0);

    // Redirect with exactly two requests in flight
    for (int i = 0; i < 20 && pend_addr.size() != 2; i++) step(100, 0, 0, 1'b0, 32'h0);
    chk("pend_before_redirect", 32'(pend_addr.size()), 32'd2);
    step(0, 0, 0, 1'b1, 32'h0000_0103);
    #2;
    chk("redirect_addr", imem_addr, 32'h0000_0100);
    chk("redirect_empty", 32'(inst_valid), 32'd0);
    repeat (15) step(100, 100, 0, 1'b0, 32'h0);

    // Address wrap at the top of the space
    step(0, 100, 0, 1'b1, 32'hFFFF_FFF8);
    grant_log.delete();
    repeat (8) step(100, 100, 0, 1'b0, 32'h0);
    chk("wrap_0", grant_log[0], 32'hFFFF_FFF8);
    chk("wrap_1", grant_log[1], 32'hFFFF_FFFC);
    chk("wrap_2", grant_log[2], 32'h0000_0000);

    // Memory withholding grants for three cycles, then one grant
    repeat (8) step(0, 100, 0, 1'b0, 32'h0);
    held = imem_addr;
    repeat (3) begin
      step(0, 100, 0, 1'b0, 32'h0);
      chk("hold_addr", imem_addr, held);
      chk("hold_req", 32'(imem_req), 32'd1);
    end
    grant_log.delete();
    step(100, 100, 0, 1'b0, 32'h0);
    repeat (5) step(0, 100, 0, 1'b0, 32'h0);
    chk("one_grant", 32'(grant_log.size()), 32'd1);
    chk("one_grant_addr", grant_log[0], held);

    // Random traffic with occasional redirects
    repeat (400) step(70, 60, 25, ($urandom_range(99) < 3), $urandom);

    // Reset asserted in the middle of a burst
    repeat (5) step(100, 50, 0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) step(80, 70, 20, ($urandom_range(99) < 3), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
